// File: rtl/timer_disp_pkg.sv
// Shared constants and types for the timer display scanner:
// 7-segment codes (gfedcba, active-low), digit count, FSM and content-select enums.
package timer_disp_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    IDLE,
    CONV
  } conv_state_e;

  typedef enum logic [1:0] {
    CONTENT_DIGIT,
    CONTENT_DASH,
    CONTENT_BLANK
  } content_e;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = SEG_0;
      4'd1:    seg_digit = SEG_1;
      4'd2:    seg_digit = SEG_2;
      4'd3:    seg_digit = SEG_3;
      4'd4:    seg_digit = SEG_4;
      4'd5:    seg_digit = SEG_5;
      4'd6:    seg_digit = SEG_6;
      4'd7:    seg_digit = SEG_7;
      4'd8:    seg_digit = SEG_8;
      4'd9:    seg_digit = SEG_9;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/timer_display_scan_if.sv
// Time-in / display-out bundle between the timer logic, the scanner and the board pins.
interface timer_display_scan_if;
  logic [1:0] min_in;
  logic [5:0] sec_in;
  logic       hold_in;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  modport master (output min_in, sec_in, hold_in, input an_n, seg_n, dp_n);
  modport slave  (input min_in, sec_in, hold_in, output an_n, seg_n, dp_n);
endinterface

// File: rtl/sec_bin2bcd.sv
// Sequential seconds-to-BCD converter: subtracts ten per cycle, flags seconds above 59.
module sec_bin2bcd
  import timer_disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] sec,
  output logic       done,
  output logic [2:0] tens,
  output logic [3:0] ones,
  output logic       inv
);

  conv_state_e state, state_nxt;
  logic [5:0]  rem, rem_nxt;
  logic [2:0]  tens_q, tens_nxt;
  logic        inv_q, inv_nxt;

  // NOTE: non-blocking for all state so every register updates together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rem    <= '0;
      tens_q <= '0;
      inv_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      rem    <= rem_nxt;
      tens_q <= tens_nxt;
      inv_q  <= inv_nxt;
    end
  end

  // NOTE: every variable gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    tens_nxt  = tens_q;
    inv_nxt   = inv_q;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CONV;
          rem_nxt   = sec;
          tens_nxt  = '0;
          inv_nxt   = (sec > 6'd59);
        end
      end
      CONV: begin
        if (inv_q || rem < 6'd10) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          rem_nxt  = rem - 6'd10;
          tens_nxt = tens_q + 3'd1;
        end
      end
    endcase
  end

  // Only meaningful while done is high; the remainder is below ten by then.
  assign tens = inv_q ? 3'd0 : tens_q;
  assign ones = inv_q ? 4'd0 : rem[3:0];
  assign inv  = inv_q;

  // The scan period guarantees a conversion finishes before the next snapshot.
  a_no_collision: assert property (@(posedge clk) disable iff (rst) !(start && state == CONV));

endmodule

// File: rtl/timer_display_scan.sv
// Multiplexed 4-digit " M:SS" driver: per-frame snapshot, BCD conversion, blink and
// registered active-low anode/segment/colon outputs.
module timer_display_scan
  import timer_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                CLK,
  input  logic                RST,
  timer_display_scan_if.slave disp
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int DIG_W   = $clog2(NUM_DIGITS);

  logic [SCAN_W-1:0]  scan_cnt;
  logic               scan_tick;
  logic [DIG_W-1:0]   dig_sel;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_wrap;
  logic               blink_ph;
  logic               snap_req;
  logic [1:0]         snap_min;

  logic               conv_done;
  logic [2:0]         conv_tens;
  logic [3:0]         conv_ones;
  logic               conv_inv;

  logic [1:0]         d_min;
  logic [2:0]         d_tens;
  logic [3:0]         d_ones;
  logic               d_inv;
  logic               expired;

  content_e           content;
  logic [3:0]         digit;
  logic [6:0]         seg_nxt;
  logic               dp_nxt;

  assign scan_tick  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign blink_wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
  assign snap_req   = scan_tick && (dig_sel == DIG_W'(NUM_DIGITS - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scan_cnt  <= '0;
      dig_sel   <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      scan_cnt  <= scan_tick ? '0 : scan_cnt + SCAN_W'(1);
      if (scan_tick) dig_sel <= dig_sel + DIG_W'(1);
      blink_cnt <= blink_wrap ? '0 : blink_cnt + BLINK_W'(1);
      if (blink_wrap) blink_ph <= ~blink_ph;
    end
  end

  sec_bin2bcd u_conv (
    .clk   (CLK),
    .rst   (RST),
    .start (snap_req),
    .sec   (disp.sec_in),
    .done  (conv_done),
    .tens  (conv_tens),
    .ones  (conv_ones),
    .inv   (conv_inv)
  );

  // Display registers change only on conv_done, all in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      snap_min <= '0;
      d_min    <= '0;
      d_tens   <= '0;
      d_ones   <= '0;
      d_inv    <= 1'b0;
    end else begin
      if (snap_req) snap_min <= disp.min_in;
      if (conv_done) begin
        d_min  <= snap_min;
        d_tens <= conv_tens;
        d_ones <= conv_ones;
        d_inv  <= conv_inv;
      end
    end
  end

  assign expired = (d_min == 2'd0) && (d_tens == 3'd0) && (d_ones == 4'd0) && !d_inv;

  always_comb begin
    content = CONTENT_BLANK;
    digit   = '0;
    case (dig_sel)
      2'd0: begin
        content = d_inv ? CONTENT_DASH : CONTENT_DIGIT;
        digit   = d_ones;
      end
      2'd1: begin
        content = d_inv ? CONTENT_DASH : CONTENT_DIGIT;
        digit   = {1'b0, d_tens};
      end
      2'd2: begin
        content = CONTENT_DIGIT;
        digit   = {2'b00, d_min};
      end
      default: ;
    endcase

    // Expiry blink is suppressed while held; slot 3 is blank regardless.
    if (expired && !disp.hold_in && blink_ph) content = CONTENT_BLANK;

    case (content)
      CONTENT_DIGIT: seg_nxt = seg_digit(digit);
      CONTENT_DASH:  seg_nxt = SEG_DASH;
      default:       seg_nxt = SEG_BLANK;
    endcase

    dp_nxt = 1'b1;
    if (dig_sel == 2'd2) dp_nxt = disp.hold_in ? ~blink_ph : 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      disp.an_n  <= 4'hF;
      disp.seg_n <= SEG_BLANK;
      disp.dp_n  <= 1'b1;
    end else begin
      disp.an_n  <= ~(4'b0001 << dig_sel);
      disp.seg_n <= seg_nxt;
      disp.dp_n  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_timer_display_scan.sv
// Scoreboard bench for timer_display_scan: a frame/blink arithmetic model predicts every
// output cycle; a negedge monitor pops and compares.
module tb_timer_display_scan;

  localparam int S     = 16;
  localparam int B     = 64;
  localparam int FRAME = 4 * S;

  logic clk = 1'b0;
  logic rst = 1'b1;

  timer_display_scan_if bus ();

  timer_display_scan #(
    .SCAN_DIV  (S),
    .BLINK_DIV (B)
  ) dut (
    .CLK  (clk),
    .RST  (rst),
    .disp (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    int mn;
    int tens;
    int ones;
    bit inv;
  } disp_t;

  disp_t       cur;
  disp_t       pend;
  bit          pend_valid;
  int          pend_edge;
  int          m;
  logic [11:0] exp_q [$];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got an/seg/dp=%h/%h/%b expected %h/%h/%b",
               name, $time, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  // Expected output registered at the edge following 'mm' edges since reset release.
  function automatic logic [11:0] expect_out(input int mm, input disp_t d, input logic hold);
    int         slot;
    bit         ph;
    bit         expired;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    slot    = (mm / S) % 4;
    ph      = ((mm / B) % 2) == 1;
    expired = (d.mn == 0) && (d.tens == 0) && (d.ones == 0) && !d.inv;
    an      = ~(4'b0001 << slot);
    case (slot)
      0:       seg = d.inv ? 7'h3F : seg_tab[d.ones];
      1:       seg = d.inv ? 7'h3F : seg_tab[d.tens];
      2:       seg = seg_tab[d.mn];
      default: seg = 7'h7F;
    endcase
    if (slot != 3 && expired && !hold && ph) seg = 7'h7F;
    dp = (slot == 2) ? (hold ? !ph : 1'b0) : 1'b1;
    return {an, seg, dp};
  endfunction

  always @(posedge clk) begin : model
    int sc;
    if (rst) begin
      m          = 0;
      cur        = '{0, 0, 0, 0};
      pend_valid = 0;
      exp_q.delete();
    end else begin
      exp_q.push_back(expect_out(m, cur, bus.hold_in));
      if (pend_valid && (m + 1) == pend_edge) begin
        cur        = pend;
        pend_valid = 0;
      end
      if (m % FRAME == FRAME - 1) begin
        sc      = int'(bus.sec_in);
        pend.mn = int'(bus.min_in);
        if (sc > 59) begin
          pend      = '{pend.mn, 0, 0, 1};
          pend_edge = m + 2;
        end else begin
          pend      = '{pend.mn, sc / 10, sc % 10, 0};
          pend_edge = m + 2 + sc / 10;
        end
        pend_valid = 1;
      end
      m++;
    end
  end

  always @(negedge clk) begin : monitor
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scan", {bus.an_n, bus.seg_n, bus.dp_n}, e);
    end
  end

  task automatic set_in(input int mn, input int sc, input bit hd);
    @(negedge clk);
    bus.min_in  = 2'(mn);
    bus.sec_in  = 6'(sc);
    bus.hold_in = hd;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_slot(input int k);
    int t = 0;
    while (((m / S) % 4) != k && t < 2 * FRAME) begin
      @(negedge clk);
      t++;
    end
    if (((m / S) % 4) != k) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_slot: slot %0d not reached within %0d cycles", k, 2 * FRAME);
    end
  endtask

  task automatic wait_snapshot();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(m > 0 && m % FRAME == 0) && t < 2 * FRAME);
    if (!(m > 0 && m % FRAME == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_snapshot: no snapshot within %0d cycles", 2 * FRAME);
    end
  endtask

  task automatic async_reset(input string name);
    #2 rst = 1'b1;
    #1 check(name, {bus.an_n, bus.seg_n, bus.dp_n}, {4'hF, 7'h7F, 1'b1});
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.min_in  = '0;
    bus.sec_in  = '0;
    bus.hold_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run(300);                 // expired 0:00 blinking
    set_in(1, 59, 0); run(200);
    set_in(2, 62, 0); run(200);
    set_in(0, 0, 1);  run(300);
    set_in(0, 0, 0);  run(200);

    set_in(0, 10, 0); run(2 * FRAME);
    wait_slot(1);
    bus.sec_in = 6'd9;        // mid-frame change must not tear the display
    run(2 * FRAME);

    run(21);
    async_reset("async_rst_midframe");
    run(150);

    set_in(3, 59, 0);
    wait_snapshot();
    async_reset("async_rst_midconv");
    run(2 * FRAME);

    for (int i = 0; i < 25; i++) begin
      set_in(int'($urandom_range(3)), int'($urandom_range(63)), $urandom_range(3) == 0);
      run(int'($urandom_range(200, 20)));
    end
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
